conv_loop_ctrl: RTL

CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

---
 rtl/conv_loop_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl
// ---------------------------------------------------------------------------
// Loop-nest sequencer for a convolution datapath. A job walks the index
// tuple (ch, row, col) col-fastest through COL_DEPTH*ROW_DEPTH*CH_DEPTH
// beats. It then waits PIPE_LAT drain cycles for the datapath to empty and
// raises a sticky done flag until software acknowledges it.
//
// Ports
//   clk           : single clock, rising edge
//   global_rst_n  : asynchronous active-low reset (release synchronised outside)
//   i_start       : start a job (looked at in IDLE only)
//   user_reset    : acknowledge and clear done (looked at in DONE only)
//   i_abort       : synchronous abort back to IDLE, highest priority
//   i_stall       : datapath back-pressure (see CONV_LOOP_CTRL_STALL_EN)
//   o_col/o_row/o_ch : registered loop indices, IDX_WIDTH bits each
//   o_valid       : index tuple is issued this cycle
//   o_last        : issued tuple is the final one of the job
//   o_busy        : block is in RUN or DRAIN
//   o_done        : sticky, registered job-complete flag
//
// Configuration macro
//   CONV_LOOP_CTRL_STALL_EN : when defined, i_stall holds the index walk.
//                             When undefined, i_stall is ignored and RUN
//                             issues a beat every cycle.
// ---------------------------------------------------------------------------
module conv_loop_ctrl #(
    parameter int COL_DEPTH = 4,
    parameter int ROW_DEPTH = 3,
    parameter int CH_DEPTH  = 2,
    parameter int IDX_WIDTH = 4,
    parameter int PIPE_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 i_start,
    input  logic                 user_reset,
    input  logic                 i_abort,
    input  logic                 i_stall,
    output logic [IDX_WIDTH-1:0] o_col,
    output logic [IDX_WIDTH-1:0] o_row,
    output logic [IDX_WIDTH-1:0] o_ch,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_WIDTH-1:0] COL_MAX = IDX_WIDTH'(COL_DEPTH - 1);
    localparam logic [IDX_WIDTH-1:0] ROW_MAX = IDX_WIDTH'(ROW_DEPTH - 1);
    localparam logic [IDX_WIDTH-1:0] CH_MAX  = IDX_WIDTH'(CH_DEPTH - 1);

    // The drain counter only has to reach PIPE_LAT-1; keep at least one bit
    // so the PIPE_LAT==0 build still elaborates (the counter is then unused).
    localparam int                  DRAIN_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0]  DRAIN_MAX = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] col_q, col_d;
    logic [IDX_WIDTH-1:0] row_q, row_d;
    logic [IDX_WIDTH-1:0] ch_q, ch_d;
    logic [DRAIN_W-1:0]   drainCnt_q, drainCnt_d;
    logic                 done_q, done_d;

    logic stallEff;
    logic colWrap;
    logic rowWrap;
    logic chWrap;

    // Back-pressure is only honoured in the stall-enabled build; otherwise
    // the port stays for pin compatibility and is tied off here.
`ifdef CONV_LOOP_CTRL_STALL_EN
    assign stallEff = i_stall;
`else
    logic unusedStall;
    assign unusedStall = i_stall;
    assign stallEff    = 1'b0;
`endif

    assign colWrap = (col_q == COL_MAX);
    assign rowWrap = (row_q == ROW_MAX);
    assign chWrap  = (ch_q == CH_MAX);

    // Handshake outputs are decoded straight from the registered state so a
    // stall suppresses the beat in the same cycle it is raised.
    assign o_valid = (state_q == RUN) && !stallEff;
    assign o_last  = o_valid && colWrap && rowWrap && chWrap;
    assign o_busy  = (state_q == RUN) || (state_q == DRAIN);
    assign o_col   = col_q;
    assign o_row   = row_q;
    assign o_ch    = ch_q;
    assign o_done  = done_q;

    // Next-state logic: abort overrides everything, then each state looks
    // only at its own qualifying input (start in IDLE, ack in DONE). The
    // last beat clears the indices so the next job starts from zero.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        ch_d       = ch_q;
        drainCnt_d = drainCnt_q;

        if (i_abort) begin
            state_d    = IDLE;
            col_d      = '0;
            row_d      = '0;
            ch_d       = '0;
            drainCnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_d = RUN;
                        col_d   = '0;
                        row_d   = '0;
                        ch_d    = '0;
                    end
                end
                RUN: begin
                    if (o_valid) begin
                        if (o_last) begin
                            col_d      = '0;
                            row_d      = '0;
                            ch_d       = '0;
                            drainCnt_d = '0;
                            state_d    = (PIPE_LAT == 0) ? DONE : DRAIN;
                        end else if (colWrap) begin
                            col_d = '0;
                            if (rowWrap) begin
                                row_d = '0;
                                ch_d  = ch_q + IDX_WIDTH'(1);
                            end else begin
                                row_d = row_q + IDX_WIDTH'(1);
                            end
                        end else begin
                            col_d = col_q + IDX_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Drain time is fixed by pipeline depth, so stall is
                    // deliberately not consulted here.
                    if (drainCnt_q == DRAIN_MAX) begin
                        drainCnt_d = '0;
                        state_d    = DONE;
                    end else begin
                        drainCnt_d = drainCnt_q + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    if (user_reset) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Done is a registered copy of "we are in DONE next cycle", which
        // makes it rise on DONE entry and drop on ack or abort.
        done_d = (state_d == DONE);
    end

    // State and index registers, cleared asynchronously by global reset.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            drainCnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ch_q       <= ch_d;
            drainCnt_q <= drainCnt_d;
            done_q     <= done_d;
        end
    end

endmodule
